// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// VGA raster timing generator in the pixel clock domain. Free-running h/v
// counters produce pixel requests (pix_x/pix_y/pix_valid/frame_start) for the
// draw block; the returned pix_data arrives DATA_LAT cycles later. It is then
// registered onto the RGB pins, together with hsync/vsync delayed to match.
//
// Ports:
//   pix_clk      pixel clock
//   rst_n        synchronous active-low reset
//   pix_x/pix_y  requested column/row (0 outside the active area)
//   pix_valid    request lies in the active area
//   frame_start  one-cycle pulse alongside the request for pixel (0,0)
//   pix_data     {R,G,B} returned by the draw block DATA_LAT cycles after request
//   vga_hs       horizontal sync pin (polarity from SYNC_POL)
//   vga_vs       vertical sync pin (polarity from SYNC_POL)
//   vga_rgb      {R,G,B} pin data, forced to 0 during blanking
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  input  logic [11:0] pix_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [11:0] vga_rgb
);

  if (DATA_LAT == 0 || DATA_LAT > 4) begin : g_lat_check
    $error("vga_timing_ctrl: DATA_LAT must be in 1..4");
  end

  localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  // Pin level while sync is not asserted.
  localparam logic        SYNC_IDLE = (SYNC_POL == 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;

  // Stage-0 decode of the raw counters.
  always_comb begin
    h_last = (h_cnt == H_TOTAL - 12'd1);
    v_last = (v_cnt == V_TOTAL - 12'd1);
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
    // Vertical sync depends on v_cnt only, so it toggles at line boundaries.
    vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 1: registered request to the draw block.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= active;
      pix_x       <= active ? h_cnt : '0;
      pix_y       <= active ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Bit [0] lines up with the request stage; bit [DATA_LAT] lines up with
  // the cycle in which the matching pix_data is presented.
  logic [DATA_LAT:0] de_sr;
  logic [DATA_LAT:0] hs_sr;
  logic [DATA_LAT:0] vs_sr;

  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[DATA_LAT-1:0], active};
      hs_sr <= {hs_sr[DATA_LAT-1:0], hs_raw};
      vs_sr <= {vs_sr[DATA_LAT-1:0], vs_raw};
    end
  end

  // Output stage: registered pins; pix_data is ignored outside the window.
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      vga_rgb <= '0;
      vga_hs  <= SYNC_IDLE;
      vga_vs  <= SYNC_IDLE;
    end else begin
      vga_rgb <= de_sr[DATA_LAT] ? pix_data : '0;
      vga_hs  <= hs_sr[DATA_LAT] ^ SYNC_IDLE;
      vga_vs  <= vs_sr[DATA_LAT] ^ SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a reduced raster so that whole frames fit in
// a short run. The reference model derives every request and pin value
// from the raster position count since reset, using plain division/modulo.
module tb_vga_timing_ctrl;

  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 6;
  localparam int VA  = 10;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int LAT = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic        pix_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_valid;
  logic        frame_start;
  logic [11:0] pix_data;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_rgb;

  int total = 0;
  int bad   = 0;
  bit white = 1'b0;

  always #5 pix_clk = ~pix_clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(0), .DATA_LAT(LAT)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_start(frame_start), .pix_data(pix_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb)
  );

  // Draw block: LAT-stage pipeline from the request; garbage when no request.
  logic [11:0] dq [LAT];
  always @(posedge pix_clk) begin
    dq[0] <= white ? 12'hFFF
           : (pix_valid ? {pix_x[3:0], pix_y[3:0], 4'hA} : 12'($urandom));
    for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
  end
  assign pix_data = dq[LAT-1];

  // Reference model ------------------------------------------------------
  typedef struct {
    bit act;
    bit hs;
    bit vs;
    bit fs;
    int x;
    int y;
  } ent_t;

  ent_t hist[$];  // hist[0] = request just registered, hist[1+LAT] = at pins
  int   pos = 0;

  function automatic ent_t blank_ent();
    ent_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic ent_t at_pos(int p);
    ent_t e;
    e.x   = p % HT;
    e.y   = p / HT;
    e.act = (e.x < HA) && (e.y < VA);
    e.hs  = (e.x >= HA + HFP) && (e.x < HA + HFP + HSW);
    e.vs  = (e.y >= VA + VFP) && (e.y < VA + VFP + VSW);
    e.fs  = (p == 0);
    return e;
  endfunction

  function automatic logic [11:0] draw_val(ent_t e);
    if (!e.act) return 12'h000;
    if (white) return 12'hFFF;
    return {4'(e.x), 4'(e.y), 4'hA};
  endfunction

  function automatic logic [25:0] req_of(ent_t e);
    return {e.act, e.fs, e.act ? 12'(e.x) : 12'd0, e.act ? 12'(e.y) : 12'd0};
  endfunction

  always @(posedge pix_clk) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < LAT + 2; i++) hist.push_back(blank_ent());
      pos = 0;
    end else begin
      hist.push_front(at_pos(pos));
      void'(hist.pop_back());
      pos = (pos + 1) % FT;
    end
  end

  // Stimulus helper: returns at the negedge on which rst_n is released.
  task automatic do_reset(int n);
    @(negedge pix_clk);
    rst_n = 1'b0;
    repeat (n) @(negedge pix_clk);
    rst_n = 1'b1;
  endtask

  // Tests ----------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge pix_clk);
    total++;
    if ({pix_valid, frame_start, pix_x, pix_y, vga_rgb, vga_hs, vga_vs} !== {2'b00, 36'd0, 2'b11}) begin
      bad++;
      $display("FAIL reset_state got v=%b fs=%b x=%0d y=%0d rgb=%h hs=%b vs=%b exp v=0 fs=0 x=0 y=0 rgb=000 hs=1 vs=1",
               pix_valid, frame_start, pix_x, pix_y, vga_rgb, vga_hs, vga_vs);
    end
    rst_n = 1'b1;
    @(negedge pix_clk);
    total++;
    if ({frame_start, pix_valid, pix_x, pix_y} !== {2'b11, 24'd0}) begin
      bad++;
      $display("FAIL first_request got fs=%b v=%b x=%0d y=%0d exp fs=1 v=1 x=0 y=0",
               frame_start, pix_valid, pix_x, pix_y);
    end
    total++;
    if ({vga_rgb, vga_hs, vga_vs} !== {12'h000, 2'b11}) begin
      bad++;
      $display("FAIL first_pins got rgb=%h hs=%b vs=%b exp rgb=000 hs=1 vs=1", vga_rgb, vga_hs, vga_vs);
    end
  endtask

  task automatic test_line_timing();
    int valid_cnt = 0, hs_low = 0, hs_fall = -1, period = -1;
    bit prev_v = 1'b0;
    do_reset($urandom_range(1, 4));
    for (int c = 0; c < 2 * HT + 4; c++) begin
      @(negedge pix_clk);
      if (c < HT) begin
        if (pix_valid) valid_cnt++;
        if (!vga_hs) begin
          hs_low++;
          if (hs_fall < 0) hs_fall = c;
        end
      end
      if (c > 0 && pix_valid && !prev_v && pix_x == 12'd0 && period < 0) period = c;
      prev_v = pix_valid;
    end
    total++;
    if (period != HT) begin bad++; $display("FAIL line_period got=%0d exp=%0d", period, HT); end
    total++;
    if (valid_cnt != HA) begin bad++; $display("FAIL line_valid_cnt got=%0d exp=%0d", valid_cnt, HA); end
    total++;
    if (hs_low != HSW) begin bad++; $display("FAIL hs_width got=%0d exp=%0d", hs_low, HSW); end
    total++;
    if (hs_fall != HA + HFP + 1 + LAT) begin
      bad++; $display("FAIL hs_fall got=%0d exp=%0d", hs_fall, HA + HFP + 1 + LAT);
    end
  endtask

  task automatic test_frame_timing();
    int period = -1, vs_low = 0, vs_fall = -1, lines = 0, maxx = 0, maxy = 0, fs_cnt = 0;
    do_reset($urandom_range(1, 4));
    for (int c = 0; c < FT + HT; c++) begin
      @(negedge pix_clk);
      if (c > 0 && frame_start && period < 0) period = c;
      if (c < FT) begin
        if (frame_start) fs_cnt++;
        if (!vga_vs) begin
          vs_low++;
          if (vs_fall < 0) vs_fall = c;
        end
        if (pix_valid) begin
          if (int'(pix_x) > maxx) maxx = int'(pix_x);
          if (int'(pix_y) > maxy) maxy = int'(pix_y);
          if (pix_x == 12'd0) lines++;
        end
      end
      if (period >= 0 && c >= FT) break;
    end
    total++;
    if (period != FT) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", period, FT); end
    total++;
    if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_count got=%0d exp=1", fs_cnt); end
    total++;
    if (vs_low != VSW * HT) begin bad++; $display("FAIL vs_width got=%0d exp=%0d", vs_low, VSW * HT); end
    total++;
    if (vs_fall != (VA + VFP) * HT + 1 + LAT) begin
      bad++; $display("FAIL vs_fall got=%0d exp=%0d", vs_fall, (VA + VFP) * HT + 1 + LAT);
    end
    total++;
    if (lines != VA) begin bad++; $display("FAIL active_lines got=%0d exp=%0d", lines, VA); end
    total++;
    if (maxx != HA - 1 || maxy != VA - 1) begin
      bad++; $display("FAIL max_xy got=%0d,%0d exp=%0d,%0d", maxx, maxy, HA - 1, VA - 1);
    end
  endtask

  task automatic test_data_alignment();
    ent_t q, p;
    int spot = -1;
    bit spot_seen = 1'b0;
    white = 1'b0;
    do_reset($urandom_range(1, 4));
    for (int c = 0; c < FT + HT; c++) begin
      @(negedge pix_clk);
      q = hist[0];
      p = hist[1+LAT];
      total++;
      if ({pix_valid, frame_start, pix_x, pix_y} !== req_of(q)) begin
        bad++;
        $display("FAIL align_req c=%0d got v=%b fs=%b x=%0d y=%0d exp=%h", c, pix_valid, frame_start, pix_x, pix_y, req_of(q));
      end
      total++;
      if ({vga_hs, vga_vs, vga_rgb} !== {~p.hs, ~p.vs, draw_val(p)}) begin
        bad++;
        $display("FAIL align_pins c=%0d got hs=%b vs=%b rgb=%h exp hs=%b vs=%b rgb=%h",
                 c, vga_hs, vga_vs, vga_rgb, ~p.hs, ~p.vs, draw_val(p));
      end
      if (c == spot) begin
        spot_seen = 1'b1;
        total++;
        if (vga_rgb !== 12'h53A) begin bad++; $display("FAIL spot_5_3 got=%h exp=53A", vga_rgb); end
      end
      if (pix_valid && pix_x == 12'd5 && pix_y == 12'd3) spot = c + 1 + LAT;
    end
    total++;
    if (!spot_seen) begin bad++; $display("FAIL spot_5_3 got=never exp=53A"); end
  endtask

  task automatic test_blanking();
    ent_t p;
    int white_cnt = 0;
    rst_n = 1'b0;
    @(negedge pix_clk);
    white = 1'b1;
    do_reset(LAT + 2);
    for (int c = 0; c < FT + HT; c++) begin
      @(negedge pix_clk);
      p = hist[1+LAT];
      if (vga_rgb == 12'hFFF) white_cnt++;
      total++;
      if (vga_rgb !== (p.act ? 12'hFFF : 12'h000)) begin
        bad++;
        $display("FAIL blank_rgb c=%0d got=%h exp=%h", c, vga_rgb, p.act ? 12'hFFF : 12'h000);
      end
    end
    total++;
    if (white_cnt < HA * VA) begin bad++; $display("FAIL blank_white_cnt got=%0d exp>=%0d", white_cnt, HA * VA); end
    rst_n = 1'b0;
    @(negedge pix_clk);
    white = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    ent_t p;
    int period;
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(1, 3));
      repeat ($urandom_range(2 * HT, FT - HT)) @(negedge pix_clk);
      rst_n = 1'b0;
      @(negedge pix_clk);
      total++;
      if ({pix_valid, frame_start, pix_x, pix_y, vga_rgb, vga_hs, vga_vs} !== {2'b00, 36'd0, 2'b11}) begin
        bad++;
        $display("FAIL midreset_state got v=%b fs=%b x=%0d y=%0d rgb=%h hs=%b vs=%b exp v=0 fs=0 x=0 y=0 rgb=000 hs=1 vs=1",
                 pix_valid, frame_start, pix_x, pix_y, vga_rgb, vga_hs, vga_vs);
      end
      rst_n = 1'b1;
      @(negedge pix_clk);
      total++;
      if ({frame_start, pix_valid, pix_x, pix_y} !== {2'b11, 24'd0}) begin
        bad++;
        $display("FAIL midreset_restart got fs=%b v=%b x=%0d y=%0d exp fs=1 v=1 x=0 y=0",
                 frame_start, pix_valid, pix_x, pix_y);
      end
      period = -1;
      for (int c = 1; c < FT + 10; c++) begin
        @(negedge pix_clk);
        p = hist[1+LAT];
        total++;
        if ({vga_hs, vga_vs, vga_rgb} !== {~p.hs, ~p.vs, draw_val(p)}) begin
          bad++;
          $display("FAIL midreset_pins c=%0d got hs=%b vs=%b rgb=%h exp hs=%b vs=%b rgb=%h",
                   c, vga_hs, vga_vs, vga_rgb, ~p.hs, ~p.vs, draw_val(p));
        end
        if (frame_start) begin
          period = c;
          break;
        end
      end
      total++;
      if (period != FT) begin bad++; $display("FAIL midreset_period got=%0d exp=%0d", period, FT); end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_data_alignment();
    test_blanking();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
